// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared constants and FSM state encoding for the multi-channel
//               DDS sequencer (channel count, accumulator/ROM widths).
// Revision    : 1.0 - initial release
// ============================================================================

// ROM address width of the attached signal_sine_rom; may be overridden by
// the build before this package is compiled.
`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif

package dds_pkg;

    localparam int N_CH    = 4;                 // number of channels
    localparam int ACC_W   = 32;                // phase accumulator / FTW width
    localparam int PHASE_W = `ROM_PHASE_BIT;    // ROM address width
    localparam int DATA_W  = 12;                // ROM sample width
    localparam int CH_W    = $clog2(N_CH);      // channel index width

    // Scheduler round state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,    // waiting for a sample tick
        ST_ISSUE = 2'd1,    // one ROM read slot per cycle
        ST_DRAIN = 2'd2     // flushing the ROM/tag pipeline
    } state_t;

endpackage : dds_pkg

`default_nettype wire

// File: rtl/dds_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_acc
// Description : One DDS channel: frequency tuning word register plus phase
//               accumulator. On 'step' the accumulator advances by the tuning
//               word when enabled, or clears when disabled.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               wr, ftw_data  - tuning word write strobe / value
//               step          - advance the accumulator this cycle
//               en            - channel enable applied on step
//               phase         - ROM-address bits of the current accumulator
//               phase_nxt     - ROM-address bits the accumulator takes on step
// Revision    : 1.0 - initial release
// ============================================================================

module dds_phase_acc #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [ACC_W-1:0]   ftw_data,
    input  logic               step,
    input  logic               en,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] phase_nxt
);

    logic [ACC_W-1:0] r_ftw;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;

    // Step uses the tuning word as registered before this cycle, so a write
    // landing in the same cycle as a step only affects the following step.
    assign w_acc_nxt = en ? (r_acc + r_ftw) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ftw <= '0;
            r_acc <= '0;
        end else begin
            if (wr) begin
                r_ftw <= ftw_data;
            end
            if (step) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    assign phase     = r_acc[ACC_W-1 -: PHASE_W];
    assign phase_nxt = w_acc_nxt[ACC_W-1 -: PHASE_W];

endmodule : dds_phase_acc

`default_nettype wire

// File: rtl/dds_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dds_channel_scheduler
// Description : Multi-channel DDS sequencer sharing one registered sine ROM.
//               A sample tick advances every enabled accumulator, then one
//               ROM read is issued per channel in a fixed round-robin slot and
//               the returned samples are tagged with their channel number.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               sample_tick              - request to start a sampling round
//               ch_en                    - per-channel enable, sampled on accept
//               ftw_wr/ftw_ch/ftw_data   - tuning word write port
//               rom_phase / rom_value    - ROM address out / data in (1 cycle)
//               sample_out/ch/valid      - tagged sample output
//               busy                     - round in progress
//               overrun                  - pulse: tick dropped while busy
// Revision    : 1.0 - initial release
// ============================================================================

module dds_channel_scheduler #(
    parameter int N_CH    = dds_pkg::N_CH,
    parameter int ACC_W   = dds_pkg::ACC_W,
    parameter int PHASE_W = dds_pkg::PHASE_W,
    parameter int DATA_W  = dds_pkg::DATA_W,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic [N_CH-1:0]    ch_en,
    input  logic               ftw_wr,
    input  logic [CH_W-1:0]    ftw_ch,
    input  logic [ACC_W-1:0]   ftw_data,
    output logic [PHASE_W-1:0] rom_phase,
    input  logic [DATA_W-1:0]  rom_value,
    output logic [DATA_W-1:0]  sample_out,
    output logic [CH_W-1:0]    sample_ch,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    import dds_pkg::*;

    localparam logic [CH_W-1:0] c_LAST_SLOT = CH_W'(N_CH - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_accept;      // tick accepted this cycle
    logic                w_issue;       // in an ISSUE slot
    logic                w_last;        // current slot is the final one
    logic                w_busy;
    logic                w_tag_load;    // a ROM read is launched this cycle

    logic [CH_W-1:0]     r_slot;
    logic [CH_W-1:0]     w_slot_inc;
    logic                r_drain;
    logic [N_CH-1:0]     r_en_q;

    logic [N_CH-1:0]     w_wr;
    logic [PHASE_W-1:0]  w_phase     [N_CH];
    logic [PHASE_W-1:0]  w_phase_nxt [N_CH];

    logic [CH_W-1:0]     w_sel;
    logic [PHASE_W-1:0]  w_rd_phase;
    logic                w_rd_en;

    logic [PHASE_W-1:0]  r_rom_phase;
    logic                r_tag1_vld;
    logic [CH_W-1:0]     r_tag1_ch;
    logic                r_tag1_en;
    logic                r_tag2_vld;
    logic [CH_W-1:0]     r_tag2_ch;
    logic                r_tag2_en;

    logic [DATA_W-1:0]   r_sample_out;
    logic [CH_W-1:0]     r_sample_ch;
    logic                r_sample_valid;
    logic                r_overrun;

    // ------------------------------------------------------------------
    // Per-channel tuning word / accumulator
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_wr[gi] = ftw_wr && (ftw_ch == CH_W'(gi));

        dds_phase_acc #(
            .ACC_W   (ACC_W),
            .PHASE_W (PHASE_W)
        ) u_phase_acc (
            .clk       (clk),
            .rst       (rst),
            .wr        (w_wr[gi]),
            .ftw_data  (ftw_data),
            .step      (w_accept),
            .en        (ch_en[gi]),
            .phase     (w_phase[gi]),
            .phase_nxt (w_phase_nxt[gi])
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sample_tick) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_slot == c_LAST_SLOT) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Second drain cycle returns to idle
                if (r_drain) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = 1'b0;
        w_issue  = 1'b0;
        w_last   = 1'b0;
        w_busy   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy   = 1'b0;
                w_accept = sample_tick;
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                w_last  = (r_slot == c_LAST_SLOT);
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux
    // The ROM address register runs one slot ahead of the slot counter so
    // that channel k's address is on rom_phase during ISSUE slot k. The read
    // for channel 0 is launched in the accept cycle itself, from the value
    // its accumulator is being loaded with; later channels read the already
    // advanced accumulators.
    // ------------------------------------------------------------------
    assign w_slot_inc = r_slot + CH_W'(1);
    assign w_sel      = w_accept ? '0 : w_slot_inc;
    assign w_rd_phase = w_accept ? w_phase_nxt[w_sel] : w_phase[w_sel];
    assign w_rd_en    = w_accept ? ch_en[w_sel] : r_en_q[w_sel];
    assign w_tag_load = w_accept || (w_issue && !w_last);

    // ------------------------------------------------------------------
    // Slot counter, address register, tag pipeline, capture register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot         <= '0;
            r_drain        <= 1'b0;
            r_en_q         <= '0;
            r_rom_phase    <= '0;
            r_tag1_vld     <= 1'b0;
            r_tag1_ch      <= '0;
            r_tag1_en      <= 1'b0;
            r_tag2_vld     <= 1'b0;
            r_tag2_ch      <= '0;
            r_tag2_en      <= 1'b0;
            r_sample_out   <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_en_q <= ch_en;
                r_slot <= '0;
            end else if (w_issue) begin
                r_slot <= w_slot_inc;
            end

            r_drain <= (r_state == ST_DRAIN) && !r_drain;

            if (w_tag_load) begin
                r_rom_phase <= w_rd_phase;
            end

            // Stage 1 travels with rom_phase, stage 2 with rom_value
            r_tag1_vld <= w_tag_load;
            r_tag1_ch  <= w_sel;
            r_tag1_en  <= w_rd_en;
            r_tag2_vld <= r_tag1_vld;
            r_tag2_ch  <= r_tag1_ch;
            r_tag2_en  <= r_tag1_en;

            // Disabled channels use their slot but leave the output untouched
            r_sample_valid <= r_tag2_vld && r_tag2_en;
            if (r_tag2_vld && r_tag2_en) begin
                r_sample_out <= rom_value;
                r_sample_ch  <= r_tag2_ch;
            end

            r_overrun <= sample_tick && w_busy;
        end
    end

    assign rom_phase    = r_rom_phase;
    assign sample_out   = r_sample_out;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign busy         = w_busy;
    assign overrun      = r_overrun;

endmodule : dds_channel_scheduler

`default_nettype wire

// File: tb/tb_dds_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_channel_scheduler
// Description : Self-checking bench for dds_channel_scheduler. A reference
//               model predicts ROM addresses, tagged samples, busy and
//               overrun per cycle; predictions queue up when stimulus is
//               driven and are compared when the cycle arrives.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_dds_channel_scheduler;

    localparam int N_CH    = 4;
    localparam int ACC_W   = 32;
    localparam int PHASE_W = 10;
    localparam int DATA_W  = 12;
    localparam int CH_W    = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_tick = 1'b0;
    logic [N_CH-1:0]    ch_en = '0;
    logic               ftw_wr = 1'b0;
    logic [CH_W-1:0]    ftw_ch = '0;
    logic [ACC_W-1:0]   ftw_data = '0;
    logic [PHASE_W-1:0] rom_phase;
    logic [DATA_W-1:0]  rom_value;
    logic [DATA_W-1:0]  sample_out;
    logic [CH_W-1:0]    sample_ch;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    dds_channel_scheduler #(
        .N_CH    (N_CH),
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W),
        .CH_W    (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .ch_en        (ch_en),
        .ftw_wr       (ftw_wr),
        .ftw_ch       (ftw_ch),
        .ftw_data     (ftw_data),
        .rom_phase    (rom_phase),
        .rom_value    (rom_value),
        .sample_out   (sample_out),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM model: distinct value per address
    function automatic logic [DATA_W-1:0] rom_fn(input logic [PHASE_W-1:0] p);
        int t;
        t = int'(p) * 11 + 7;
        return t[DATA_W-1:0];
    endfunction

    always @(posedge clk) rom_value <= rom_fn(rom_phase);

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        ph_q[$];
    exp_t        smp_q[$];
    int          ovr_q[$];
    logic [31:0] m_ftw [N_CH];
    logic [31:0] m_acc [N_CH];
    int          busy_lo = 1;
    int          busy_hi = 0;
    bit          mon_en  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle monitor on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   exp_sv;
            bit   exp_ov;
            if (ph_q.size() > 0 && ph_q[0].cyc == cyc) begin
                e = ph_q.pop_front();
                check("rom_phase", rom_phase, e.a);
            end
            exp_sv = (smp_q.size() > 0 && smp_q[0].cyc == cyc);
            check("sample_valid", sample_valid, exp_sv);
            if (exp_sv) begin
                e = smp_q.pop_front();
                check("sample_ch", sample_ch, e.a);
                check("sample_out", sample_out, e.b);
            end
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            exp_ov = (ovr_q.size() > 0 && ovr_q[0] == cyc);
            if (exp_ov) void'(ovr_q.pop_front());
            check("overrun", overrun, exp_ov);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: drive one cycle and update the model
    // ------------------------------------------------------------------
    task automatic drive(input bit tick, input logic [N_CH-1:0] en,
                         input bit wr, input int wch, input logic [31:0] wdata);
        logic [PHASE_W-1:0] ph;
        @(posedge clk); #1;
        rst         = 1'b0;
        sample_tick = tick;
        ch_en       = en;
        ftw_wr      = wr;
        ftw_ch      = wch[CH_W-1:0];
        ftw_data    = wdata;
        if (tick) begin
            if (cyc >= busy_lo && cyc <= busy_hi) begin
                ovr_q.push_back(cyc + 1);
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    m_acc[k] = en[k] ? (m_acc[k] + m_ftw[k]) : 32'h0;
                    ph = m_acc[k][31:22];
                    ph_q.push_back('{cyc + 1 + k, 32'(ph), 32'h0});
                    if (en[k]) smp_q.push_back('{cyc + 3 + k, 32'(k), 32'(rom_fn(ph))});
                end
                busy_lo = cyc + 1;
                busy_hi = cyc + N_CH + 2;
            end
        end
        if (wr) m_ftw[wch] = wdata;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 0, 32'h0);
    endtask

    task automatic wr_ftw(input int ch, input logic [31:0] v);
        drive(1'b0, '0, 1'b1, ch, v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_phase"},    rom_phase,    0);
        check({tag, "_sample_out"},   sample_out,   0);
        check({tag, "_sample_ch"},    sample_ch,    0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_overrun"},      overrun,      0);
    endtask

    // Reset for one cycle; anything predicted after that cycle is discarded
    task automatic do_reset(input string tag);
        exp_t tq[$];
        int   oq[$];
        @(posedge clk); #1;
        rst = 1'b1; sample_tick = 1'b0; ftw_wr = 1'b0; ch_en = '0;
        foreach (ph_q[i])  if (ph_q[i].cyc <= cyc)  tq.push_back(ph_q[i]);
        ph_q = tq;
        tq = {};
        foreach (smp_q[i]) if (smp_q[i].cyc <= cyc) tq.push_back(smp_q[i]);
        smp_q = tq;
        foreach (ovr_q[i]) if (ovr_q[i] <= cyc) oq.push_back(ovr_q[i]);
        ovr_q = oq;
        if (busy_hi > cyc) busy_hi = cyc;
        for (int k = 0; k < N_CH; k++) begin
            m_acc[k] = 32'h0;
            m_ftw[k] = 32'h0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs(tag);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int t;
        for (int k = 0; k < N_CH; k++) begin
            m_acc[k] = 32'h0;
            m_ftw[k] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        check_reset_outputs("por");

        // Single enabled channel
        wr_ftw(0, 32'h0100_0000);
        drive(1'b1, 4'b0001, 1'b0, 0, 32'h0);
        t = cyc;
        idle(1);
        check("s1_phase_t1", rom_phase, 10'h004);
        idle(2);
        check("s1_valid_t3", sample_valid, 1'b1);
        check("s1_ch_t3", sample_ch, 2'd0);
        check("s1_out_t3", sample_out, rom_fn(10'h004));
        idle(4);
        check("s1_busy_t7", busy, 1'b0);
        check("s1_elapsed", cyc - t, 7);

        // All channels, three rounds spaced 7 cycles
        do_reset("r2");
        for (int k = 0; k < N_CH; k++) wr_ftw(k, 32'h0040_0000 * (k + 1));
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 4'b1111, 1'b0, 0, 32'h0);
            t = cyc;
            idle(6);
        end
        check("s2_r3_ch3_phase", 32'(ph_q.size()), 0);
        drive(1'b1, 4'b1111, 1'b0, 0, 32'h0);
        idle(4);
        check("s2_r4_ch3_phase", rom_phase, 10'd16);
        idle(4);

        // Negative step wraps below zero
        do_reset("r3");
        wr_ftw(1, 32'hFFC0_0000);
        drive(1'b1, 4'b0010, 1'b0, 0, 32'h0);
        idle(2);
        check("s3_wrap1", rom_phase, 10'h3FF);
        idle(5);
        drive(1'b1, 4'b0010, 1'b0, 0, 32'h0);
        idle(2);
        check("s3_wrap2", rom_phase, 10'h3FE);
        idle(6);

        // Tick while busy is dropped and flagged
        wr_ftw(2, 32'h0123_4567);
        drive(1'b1, 4'b1111, 1'b0, 0, 32'h0);
        idle(2);
        drive(1'b1, 4'b1111, 1'b0, 0, 32'h0);
        idle(1);
        check("s4_overrun", overrun, 1'b1);
        idle(2);
        drive(1'b1, 4'b0101, 1'b0, 0, 32'h0);
        idle(1);
        check("s4_accept_busy", busy, 1'b1);
        idle(7);

        // Tuning word write coinciding with an accepted tick
        do_reset("r5");
        wr_ftw(0, 32'h0100_0000);
        drive(1'b1, 4'b0001, 1'b1, 0, 32'h0200_0000);
        idle(1);
        check("s5_old_ftw", rom_phase, 10'h004);
        idle(5);
        drive(1'b1, 4'b0001, 1'b0, 0, 32'h0);
        idle(1);
        check("s5_new_ftw", rom_phase, 10'h00C);
        idle(7);

        // Reset in the middle of a round
        for (int k = 0; k < N_CH; k++) wr_ftw(k, 32'h0050_0000 * (k + 3));
        drive(1'b1, 4'b1111, 1'b0, 0, 32'h0);
        idle(3);
        do_reset("s6_midround");
        idle(6);
        drive(1'b1, 4'b1011, 1'b0, 0, 32'h0);
        idle(1);
        check("s6_fresh_phase", rom_phase, 10'h000);
        idle(9);

        check("ph_q_empty",  32'(ph_q.size()),  0);
        check("smp_q_empty", 32'(smp_q.size()), 0);
        check("ovr_q_empty", 32'(ovr_q.size()), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dds_channel_scheduler

`default_nettype wire

// File: doc/dds_channel_scheduler.md
# dds_channel_scheduler

Multi-channel DDS sequencer that shares one registered sine ROM among N_CH independent phase accumulators. On each sample tick it advances all enabled accumulators by their frequency tuning words. It then issues one ROM read per channel in a fixed round-robin slot and returns the samples tagged with channel number. It sits between the control/register interface (FTW writes, enables) and the signal_sine_rom instance plus downstream DAC/mixer logic.

## Interface
- N_CH, 4: number of channels (power of two, ≥2)
- ACC_W, 32: phase accumulator / FTW width
- PHASE_W, 10: ROM address width; equals `ROM_PHASE_BIT`
- DATA_W, 12: ROM sample width
- CH_W, $clog2(N_CH): channel index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sample_tick  in  1  one-cycle request to start a sampling round
- ch_en  in  N_CH  per-channel enable, sampled at accepted tick
- ftw_wr  in  1  write strobe for a tuning word
- ftw_ch  in  CH_W  channel addressed by ftw_wr
- ftw_data  in  ACC_W  tuning word value
- rom_phase  out  PHASE_W  address to ROM (registered)
- rom_value  in  DATA_W  ROM data, valid 1 cycle after rom_phase
- sample_out  out  DATA_W  captured sample
- sample_ch  out  CH_W  channel of sample_out
- sample_valid  out  1  sample_out/sample_ch valid this cycle
- busy  out  1  round in progress; ticks not accepted
- overrun  out  1  one-cycle pulse: tick dropped because busy

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: sample_tick=1 → accept: for each ch, acc[ch] <= ch_en[ch] ? acc[ch]+ftw[ch] (mod 2^ACC_W) : 0; latch ch_en into en_q; slot counter <= 0; go ISSUE.
- ISSUE: one slot per cycle, ch = slot: rom_phase <= acc[ch][ACC_W-1 -: PHASE_W]; en_q[ch] and ch travel down a 2-stage tag pipeline aligned with ROM latency. After slot N_CH-1 → DRAIN.
- DRAIN: 2 cycles (pipeline flush) → IDLE.
- Capture: when tag stage-2 valid, sample_out <= rom_value, sample_ch <= tag ch, sample_valid <= en_q bit. Disabled channels consume a slot but produce no sample_valid; sample_out/sample_ch hold.
- FTW write: ftw[ftw_ch] <= ftw_data any cycle, including while busy. Accumulation uses ftw value registered before the tick cycle; write coinciding with accepted tick takes effect at next round.
- Tick while busy (ISSUE/DRAIN) → dropped, overrun=1 next cycle; round unaffected.
- Phase wraps naturally modulo 2^ACC_W; no saturation.

## Timing
- Reset values: rom_phase=0, sample_out=0, sample_ch=0, sample_valid=0, busy=0, overrun=0; all acc and ftw = 0; FSM IDLE; tag pipeline cleared.
- Tick accepted in cycle T. busy=1 from T+1 through T+N_CH+2 inclusive.
- rom_phase for ch k presented in cycle T+1+k; ROM data in T+2+k; sample_valid for ch k in T+3+k.
- Earliest next accepted tick: T+N_CH+3 (1 cycle after busy falls; first cycle busy=0 accepts).
- Reset mid-round: next cycle all outputs at reset values, in-flight samples discarded, no sample_valid after reset.
- Exactly N_CH slots per round regardless of ch_en; ch_en changes during round ignored.

## Structure
- Package dds_pkg: N_CH, ACC_W, PHASE_W (= `ROM_PHASE_BIT`), DATA_W, CH_W constants; FSM state enum.
- Sub-module dds_phase_acc: one ftw register + accumulator (ports clk, rst, wr, ftw_data, step, en, phase); instantiated N_CH times; scheduler holds FSM, slot counter, read mux, tag pipeline, capture register.

## Test plan
- Reset, ftw[0]=0x0100_0000, ch_en=4'b0001, one tick → rom_phase=0x004 in T+1; sample_valid only at T+3 with sample_ch=0, sample_out=rom[4]; busy low at T+7.
- ftw[0..3]=0x0040_0000×(k+1), all enabled, 3 ticks spaced 7 cycles → ch k phase after round 3 = 3·(k+1); sample_valid at T+3..T+6, sample_ch 0,1,2,3.
- ftw[1]=0xFFC0_0000 (-1 phase step), 2 ticks → ch1 phase 0x3FF then 0x3FE (wrap).
- Tick at T, second tick at T+3 → overrun=1 at T+4, only 4 samples; tick at T+7 accepted.
- ftw_wr to ch0 with 0x0200_0000 in same cycle as tick (old 0x0100_0000) → this round phase 0x004, next 0x00C.
- rst asserted at T+4 of a round → T+5 all outputs 0, no further sample_valid; fresh tick starts phase from 0+ftw... ftw=0 so phase 0.
